// File: rtl/imc_pkg.sv
// imc_pkg: state encoding, control bundle and per-state decode constants for imc_ctrl
package imc_pkg;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_LOAD     = 3'd1,
      S_DET      = 3'd2,
      S_RECIP    = 3'd3,
      S_SCALE_AD = 3'd4,
      S_SCALE_BC = 3'd5,
      S_DONE     = 3'd6
   } state_t;

   typedef struct packed {
      logic valid;
      logic en_a;
      logic en_b;
      logic en_c;
      logic en_d;
      logic en_det;
      logic en_term;
      logic neg_b;
      logic sel_a;
      logic sel_b;
      logic sel_c;
      logic sel_d;
      logic sel_mul_a_0;
      logic sel_mul_b_0;
      logic sel_mul_a_1;
      logic sel_mul_b_1;
   } ctrl_t;

   localparam ctrl_t C_LOAD = '{en_a: 1'b1, en_b: 1'b1, en_c: 1'b1, en_d: 1'b1, default: 1'b0};
   localparam ctrl_t C_DET = '{en_det: 1'b1, neg_b: 1'b1, default: 1'b0};
   localparam ctrl_t C_RECIP = '{en_term: 1'b1, default: 1'b0};
   localparam ctrl_t C_SCALE_AD = '{en_a: 1'b1, en_d: 1'b1, sel_a: 1'b1, sel_d: 1'b1,
                                    sel_mul_a_0: 1'b1, sel_mul_a_1: 1'b1, sel_mul_b_1: 1'b1,
                                    default: 1'b0};
   localparam ctrl_t C_SCALE_BC = '{en_b: 1'b1, en_c: 1'b1, sel_b: 1'b1, sel_c: 1'b1,
                                    sel_mul_a_0: 1'b1, sel_mul_b_0: 1'b1, sel_mul_b_1: 1'b1,
                                    default: 1'b0};
   localparam ctrl_t C_DONE = '{valid: 1'b1, default: 1'b0};

endpackage

// File: rtl/imc_ctrl.sv
// imc_ctrl: Moore sequencer driving a 2x2 matrix-inversion datapath
module imc_ctrl
   import imc_pkg::*;
(
   input  logic clk_i,
   input  logic rst_i,
   input  logic start_i,
   input  logic ack_i,
   output logic ready_o,
   output logic valid_o,
   output logic en_a_o,
   output logic en_b_o,
   output logic en_c_o,
   output logic en_d_o,
   output logic en_det_o,
   output logic en_term_o,
   output logic neg_b_o,
   output logic sel_a_o,
   output logic sel_b_o,
   output logic sel_c_o,
   output logic sel_d_o,
   output logic sel_mul_a_0_o,
   output logic sel_mul_b_0_o,
   output logic sel_mul_a_1_o,
   output logic sel_mul_b_1_o
);

   state_t state, state_nxt;
   ctrl_t  ctrl;

   // state register; reset returns to IDLE and aborts any inversion in flight
   always_ff @(posedge clk_i) begin
      if (rst_i) state <= S_IDLE;
      else       state <= state_nxt;
   end

   // next-state and per-state decode; unused encodings fall back to IDLE with everything low
   always_comb begin
      state_nxt = S_IDLE;
      ctrl      = '0;
      case (state)
         S_IDLE:     state_nxt = start_i ? S_LOAD : S_IDLE;
         S_LOAD:     begin ctrl = C_LOAD;     state_nxt = S_DET;      end
         S_DET:      begin ctrl = C_DET;      state_nxt = S_RECIP;    end
         S_RECIP:    begin ctrl = C_RECIP;    state_nxt = S_SCALE_AD; end
         S_SCALE_AD: begin ctrl = C_SCALE_AD; state_nxt = S_SCALE_BC; end
         S_SCALE_BC: begin ctrl = C_SCALE_BC; state_nxt = S_DONE;     end
         S_DONE:     begin ctrl = C_DONE;     state_nxt = ack_i ? S_IDLE : S_DONE; end
         default:    state_nxt = S_IDLE;
      endcase
   end

   // reset gates enables and valid immediately so no register is written on the reset edge
   assign ready_o       = (state == S_IDLE);
   assign valid_o       = ctrl.valid   & ~rst_i;
   assign en_a_o        = ctrl.en_a    & ~rst_i;
   assign en_b_o        = ctrl.en_b    & ~rst_i;
   assign en_c_o        = ctrl.en_c    & ~rst_i;
   assign en_d_o        = ctrl.en_d    & ~rst_i;
   assign en_det_o      = ctrl.en_det  & ~rst_i;
   assign en_term_o     = ctrl.en_term & ~rst_i;
   assign neg_b_o       = ctrl.neg_b;
   assign sel_a_o       = ctrl.sel_a;
   assign sel_b_o       = ctrl.sel_b;
   assign sel_c_o       = ctrl.sel_c;
   assign sel_d_o       = ctrl.sel_d;
   assign sel_mul_a_0_o = ctrl.sel_mul_a_0;
   assign sel_mul_b_0_o = ctrl.sel_mul_b_0;
   assign sel_mul_a_1_o = ctrl.sel_mul_a_1;
   assign sel_mul_b_1_o = ctrl.sel_mul_b_1;

endmodule

// File: tb/tb_imc_ctrl.sv
// tb_imc_ctrl: randomized self-checking bench for imc_ctrl against a phase-count model
module tb_imc_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1, start = 1'b0, ack = 1'b0;
   logic ready, valid, en_a, en_b, en_c, en_d, en_det, en_term, neg_b;
   logic sel_a, sel_b, sel_c, sel_d, sm_a0, sm_b0, sm_a1, sm_b1;
   int   errors = 0, checks = 0;
   int   ph = 0;
   logic signed [15:0] ia = 16'sh0200, ib = 16'sh0, ic = 16'sh0, id = 16'sh0200;
   logic signed [15:0] ra, rb, rc, rd, rdet, rterm;

   imc_ctrl dut (
      .clk_i(clk), .rst_i(rst), .start_i(start), .ack_i(ack),
      .ready_o(ready), .valid_o(valid),
      .en_a_o(en_a), .en_b_o(en_b), .en_c_o(en_c), .en_d_o(en_d),
      .en_det_o(en_det), .en_term_o(en_term), .neg_b_o(neg_b),
      .sel_a_o(sel_a), .sel_b_o(sel_b), .sel_c_o(sel_c), .sel_d_o(sel_d),
      .sel_mul_a_0_o(sm_a0), .sel_mul_b_0_o(sm_b0),
      .sel_mul_a_1_o(sm_a1), .sel_mul_b_1_o(sm_b1)
   );

   always #5 clk = ~clk;

   function automatic logic signed [15:0] mulq(input logic signed [15:0] x, input logic signed [15:0] y);
      int t;
      t = int'(x) * int'(y);
      return 16'(t >>> 8);
   endfunction

   // behavioural Q8.8 datapath steered by the controller outputs
   always @(posedge clk) begin
      if (en_a) ra <= sel_a ? mulq(rterm, rd) : ia;
      if (en_b) rb <= sel_b ? mulq(rb, rterm) : ib;
      if (en_c) rc <= sel_c ? mulq(rterm, rc) : ic;
      if (en_d) rd <= sel_d ? mulq(ra, rterm) : id;
      if (en_det) rdet <= mulq(ra, rd) + mulq(neg_b ? -rb : rb, rc);
      if (en_term) rterm <= (rdet == 0) ? 16'sh7fff : 16'(65536 / (rdet < 0 ? -int'(rdet) : int'(rdet)));
   end

   // {ready, valid, en_a..d, en_det, en_term, neg_b, sel_a..d, sel_mul a0 b0 a1 b1}
   function automatic logic [16:0] exp_ctrl(input int p, input logic r);
      logic [16:0] v;
      case (p)
         0:       v = 17'b1_0_0000_00_0_0000_0000;
         1:       v = 17'b0_0_1111_00_0_0000_0000;
         2:       v = 17'b0_0_0000_10_1_0000_0000;
         3:       v = 17'b0_0_0000_01_0_0000_0000;
         4:       v = 17'b0_0_1001_00_0_1001_1011;
         5:       v = 17'b0_0_0110_00_0_0110_1101;
         default: v = 17'b0_1_0000_00_0_0000_0000;
      endcase
      return r ? (v & ~17'h0FE00) : v;
   endfunction

   function automatic int next_ph(input int p, input logic s, input logic a, input logic r);
      if (r) return 0;
      if (p == 0) return s ? 1 : 0;
      if (p == 6) return a ? 0 : 6;
      return p + 1;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h (t=%0t ph=%0d)", tag, got, exp, $time, ph);
      end
   endtask

   task automatic step(input logic s, input logic a, input logic r);
      start = s; ack = a; rst = r;
      #1;
      chk("ctrl", 32'({ready, valid, en_a, en_b, en_c, en_d, en_det, en_term, neg_b,
                       sel_a, sel_b, sel_c, sel_d, sm_a0, sm_b0, sm_a1, sm_b1}), 32'(exp_ctrl(ph, r)));
      @(posedge clk);
      ph = next_ph(ph, s, a, r);
      #1;
   endtask

   initial begin
      @(posedge clk); #1;
      step(0, 0, 1);
      step(0, 0, 1);
      repeat (10) step(0, 0, 0);
      step(1, 0, 0);
      repeat (5) step(0, 0, 0);
      chk("valid_at_6", 32'(valid), 32'd1);
      chk("det", 32'(rdet), 32'h0400);
      chk("term", 32'(rterm), 32'h0040);
      chk("a_final", 32'(ra), 32'h0080);
      chk("d_final", 32'(rd), 32'h0080);
      chk("b_final", 32'(rb), 32'h0);
      chk("c_final", 32'(rc), 32'h0);
      repeat (20) step(0, 0, 0);
      chk("held_valid", 32'(valid), 32'd1);
      step(0, 1, 0);
      chk("ready_after_ack", 32'(ready), 32'd1);
      step(1, 0, 0);
      step(1, 0, 0);
      step(1, 1, 0);
      repeat (3) step(1, 0, 0);
      chk("no_early_exit", 32'(valid), 32'd1);
      step(1, 1, 0);
      chk("idle_after_ack", 32'(ready), 32'd1);
      step(1, 0, 0);
      chk("reload", 32'(en_a), 32'd1);
      repeat (3) step(0, 0, 0);
      rst = 1'b1; #1;
      chk("abort_en_ad", 32'({en_a, en_d}), 32'd0);
      step(0, 0, 1);
      chk("abort_idle", 32'(ready), 32'd1);
      repeat (5) step(0, 0, 0);
      for (int i = 0; i < 400; i++)
         step(($urandom_range(2) == 0), ($urandom_range(3) == 0), ($urandom_range(40) == 0));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/imc_ctrl.md
IMC_CTRL -- requirements
Module: imc_ctrl

Interface
REQ-001 SHALL have port clk_i  input  1  single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_i  input  1  reset, synchronous and active-high.
REQ-003 SHALL have port start_i  input  1  request one inversion; sampled only in IDLE.
REQ-004 SHALL have port ready_o  output  1  high exactly when state is IDLE (request accepted).
REQ-005 SHALL have port valid_o  output  1  result (a..d and signs in datapath) valid; high exactly in DONE.
REQ-006 SHALL have port ack_i  input  1  consumer has taken result; sampled only in DONE.
REQ-007 SHALL have ports en_a_o, en_b_o, en_c_o, en_d_o, en_det_o, en_term_o  output  1 each  datapath register enables.
REQ-008 SHALL have ports neg_b_o, sel_a_o, sel_b_o, sel_c_o, sel_d_o  output  1 each  datapath negate/load selects.
REQ-009 SHALL have ports sel_mul_a_0_o, sel_mul_b_0_o, sel_mul_a_1_o, sel_mul_b_1_o  output  1 each  multiplier operand selects.

Function
REQ-010 SHALL implement a Moore FSM: IDLE, LOAD, DET, RECIP, SCALE_AD, SCALE_BC, DONE.
REQ-011 SHALL transition IDLE->LOAD when start_i=1, else stay in IDLE.
REQ-012 SHALL transition LOAD->DET->RECIP->SCALE_AD->SCALE_BC->DONE unconditionally, one cycle each.
REQ-013 SHALL transition DONE->IDLE when ack_i=1; otherwise hold DONE, with datapath enables low so the result is stable.
REQ-014 SHALL ignore start_i outside IDLE and ack_i outside DONE; start_i and ack_i both high in DONE gives DONE->IDLE only.
REQ-015 SHALL decode every control output combinationally from state only. Any output not listed for a state is 0.
REQ-016 LOAD decode: en_a..en_d=1, sel_a..sel_d=0. Capture a_i..d_i; the requester holds them stable through LOAD.
REQ-017 DET decode: en_det=1, neg_b=1, all sel_mul=0. det <= a*d + (-b)*c.
REQ-018 RECIP decode: en_term=1. term <= reciprocal(|det|).
REQ-019 SCALE_AD decode: en_a=1, en_d=1, sel_a=1, sel_d=1, sel_mul_a_0=1, sel_mul_b_0=0, sel_mul_a_1=1, sel_mul_b_1=1. a <= term*d and d <= a*term, same edge.
REQ-020 SCALE_BC decode: en_b=1, en_c=1, sel_b=1, sel_c=1, neg_b=0, sel_mul_a_0=1, sel_mul_b_0=1, sel_mul_a_1=0, sel_mul_b_1=1. b <= b*term and c <= term*c.
REQ-021 Latency: start_i accepted at edge N -> valid_o=1 from cycle N+6; back-to-back throughput is 1 inversion per 7 cycles, plus ack wait.
REQ-022 SHALL never assert two writers to one register in the same cycle; at most one FSM state is active per cycle.
REQ-023 Unreachable state encodings SHALL go to IDLE on the next edge with all outputs 0.

Reset
REQ-024 While rst_i=1, all enable outputs and valid_o SHALL be forced to 0 combinationally, in any state.
REQ-025 On a rising edge with rst_i=1, state SHALL become IDLE. After reset: ready_o=1, valid_o=0, all selects and neg_b=0.
REQ-026 Reset mid-operation (any state) SHALL abort the inversion; no datapath register may be written after the reset edge until a new start_i.

Structure
REQ-027 Package imc_pkg SHALL hold the state enum, the control bundle struct (all 16 control bits), and the per-state decode constants.
REQ-028 No sub-module: decode is one case statement over state. Integration with the datapath is in a separate top (imc_top), outside this block.

Verification
REQ-029 Reset then idle: rst_i=1 for 2 cycles, then release -> ready_o=1, valid_o=0, all 16 control outputs 0, stable for 10 cycles without start_i.
REQ-030 Single run: start_i=1 for 1 cycle -> state sequence LOAD, DET, RECIP, SCALE_AD, SCALE_BC, then valid_o=1 at cycle 6. Each cycle's control bits exactly match REQ-016..REQ-020.
REQ-031 Held result: no ack_i for 20 cycles in DONE -> valid_o stays 1, all enables 0. ack_i=1 -> ready_o=1 next cycle.
REQ-032 Ignored requests: start_i=1 held throughout a run, ack_i pulsed during DET -> no restart and no early exit. After ack in DONE with start_i still 1 -> IDLE then LOAD.
REQ-033 Abort: rst_i=1 during SCALE_AD -> en_a, en_d low in that same cycle; IDLE next cycle; no enable asserts until a new start_i.
REQ-034 End-to-end with datapath model: a=0x0200, b=0, c=0, d=0x0200 (Q8.8 2.0 identity scale) -> det=0x0400. Final a, d equal term*d and a*term per datapath rules; b=c=0.
